// File: rtl/sm_trace_buffer_if.sv
// sm_trace_buffer_if: retired-instruction stream and trace readout bus for sm_trace_buffer
//   cpu_valid/cpu_pc/cpu_instr : retired instruction from the core
//   rd_idx                     : readout index, 0 = oldest entry
//   rd_pc/rd_instr/rd_cycle    : registered readout data
//   master = core/debugger side, slave = trace buffer side
interface sm_trace_buffer_if #(
   parameter int DEPTH   = 16,
   parameter int CYCLE_W = 16
);
   localparam int AW = $clog2(DEPTH);
   logic               cpu_valid;
   logic [31:0]        cpu_pc;
   logic [31:0]        cpu_instr;
   logic [AW-1:0]      rd_idx;
   logic [31:0]        rd_pc;
   logic [31:0]        rd_instr;
   logic [CYCLE_W-1:0] rd_cycle;
   modport master (
      output cpu_valid, cpu_pc, cpu_instr, rd_idx,
      input  rd_pc, rd_instr, rd_cycle
   );
   modport slave (
      input  cpu_valid, cpu_pc, cpu_instr, rd_idx,
      output rd_pc, rd_instr, rd_cycle
   );
endinterface

// File: rtl/sm_trace_buffer.sv
// sm_trace_buffer: circular instruction trace buffer with PC/instr trigger, post-trigger capture, timeout and stop
//   clk, rst (async, active-high)   : clock and reset
//   bus (slave)                     : retired instruction stream in, trace readout out
//   arm, stop                       : start a run / end a run manually
//   trig_mode, trig_value           : 00 none, 01 PC match, 10 instr match, 11 either
//   timeout                         : capture cycle limit, 0 disables
//   count, cycle                    : valid entries, current capture cycle
//   busy, done, trig_hit, timeout_hit : run status
module sm_trace_buffer #(
   parameter int DEPTH     = 16,
   parameter int CYCLE_W   = 16,
   parameter int POST_TRIG = 4,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   sm_trace_buffer_if.slave   bus,
   input  logic               arm,
   input  logic               stop,
   input  logic [1:0]         trig_mode,
   input  logic [31:0]        trig_value,
   input  logic [CYCLE_W-1:0] timeout,
   output logic [AW:0]        count,
   output logic [CYCLE_W-1:0] cycle,
   output logic               busy,
   output logic               done,
   output logic               trig_hit,
   output logic               timeout_hit
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] POST    = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;
   localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
   logic [1:0]         state, nextState;
   logic [AW-1:0]      wrPtr, postCnt, rdAddr;
   logic               active, start, wrEn, trigNow, toNow, endNow, lastPost;
   logic [31:0]        memPc    [DEPTH];
   logic [31:0]        memInstr [DEPTH];
   logic [CYCLE_W-1:0] memCycle [DEPTH];
   assign busy     = active;
   assign done     = state == DONE;
   assign active   = state == CAPTURE || state == POST;
   assign start    = arm && (state == IDLE || state == DONE);
   assign wrEn     = active && bus.cpu_valid;
   assign trigNow  = state == CAPTURE && bus.cpu_valid &&
                     ((trig_mode[0] && bus.cpu_pc == trig_value) ||
                      (trig_mode[1] && bus.cpu_instr == trig_value));
   assign toNow    = active && timeout != '0 && cycle == timeout;
   assign endNow   = (active && stop) || toNow;
   assign lastPost = state == POST && bus.cpu_valid && postCnt == AW'(1);
   // Index 0 is the oldest entry, i.e. count entries behind the write pointer.
   assign rdAddr   = wrPtr - count[AW-1:0] + bus.rd_idx;
   always_comb begin
      nextState = (state == CAPTURE) ? (endNow ? DONE : trigNow ? ((POST_TRIG == 0) ? DONE : POST) : CAPTURE) :
                  (state == POST)    ? ((endNow || lastPost) ? DONE : POST) :
                  start              ? CAPTURE : state;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state        <= IDLE;
         wrPtr        <= '0;
         postCnt      <= '0;
         count        <= '0;
         cycle        <= '0;
         trig_hit     <= 1'b0;
         timeout_hit  <= 1'b0;
         bus.rd_pc    <= '0;
         bus.rd_instr <= '0;
         bus.rd_cycle <= '0;
      end else begin
         state <= nextState;
         if (start) begin
            wrPtr       <= '0;
            count       <= '0;
            cycle       <= '0;
            trig_hit    <= 1'b0;
            timeout_hit <= 1'b0;
         end else if (active) begin
            if (cycle != '1) cycle <= cycle + 1'b1;
            if (bus.cpu_valid) begin
               wrPtr <= wrPtr + 1'b1;
               if (count != FULL) count <= count + 1'b1;
            end
            if (trigNow) begin
               trig_hit <= 1'b1;
               postCnt  <= AW'(POST_TRIG);
            end else if (state == POST && bus.cpu_valid) postCnt <= postCnt - 1'b1;
            if (toNow) timeout_hit <= 1'b1;
         end
         // Memory reads are taken before this edge's write lands, so a same-address
         // read returns the old contents.
         bus.rd_pc    <= ({1'b0, bus.rd_idx} < count) ? memPc[rdAddr]    : '0;
         bus.rd_instr <= ({1'b0, bus.rd_idx} < count) ? memInstr[rdAddr] : '0;
         bus.rd_cycle <= ({1'b0, bus.rd_idx} < count) ? memCycle[rdAddr] : '0;
      end
   always_ff @(posedge clk)
      if (wrEn && !rst) begin
         memPc[wrPtr]    <= bus.cpu_pc;
         memInstr[wrPtr] <= bus.cpu_instr;
         memCycle[wrPtr] <= cycle;
      end
endmodule

// File: doc/sm_trace_buffer.md
SM_TRACE_BUFFER -- requirements
Module: sm_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of trace entries; power of two, >=4; AW = log2(DEPTH).
REQ-002 SHALL have parameter CYCLE_W, default 16, width of the cycle counter and of each stored timestamp.
REQ-003 SHALL have parameter POST_TRIG, default 4, entries captured after the trigger; legal range 0..DEPTH-1.
REQ-004 SHALL have ports, clock and reset first (one clock; reset is asynchronous and active-high):
  clk  in  1  single clock, all state on rising edge
  rst  in  1  asynchronous active-high reset
  arm  in  1  start capture (level sampled per cycle)
  stop  in  1  manual stop request
  cpu_valid  in  1  instruction retired this cycle
  cpu_pc  in  32  PC of retired instruction
  cpu_instr  in  32  retired instruction word
  trig_mode  in  2  00 none, 01 PC match, 10 instr match, 11 either
  trig_value  in  32  compare value
  timeout  in  CYCLE_W  capture cycle limit; 0 disables
  rd_idx  in  AW  readout index, 0 = oldest entry
  rd_pc  out  32  stored PC at rd_idx
  rd_instr  out  32  stored instruction at rd_idx
  rd_cycle  out  CYCLE_W  stored timestamp at rd_idx
  count  out  AW+1  valid entries, 0..DEPTH
  cycle  out  CYCLE_W  current capture cycle counter
  busy  out  1  state is CAPTURE or POST
  done  out  1  state is DONE
  trig_hit  out  1  trigger occurred in this run
  timeout_hit  out  1  timeout ended this run

Function
REQ-005 SHALL implement states IDLE, CAPTURE, POST, DONE.
REQ-006 arm=1 in IDLE or DONE SHALL enter CAPTURE next edge, clearing count, write pointer, cycle, trig_hit and timeout_hit; arm SHALL be ignored in CAPTURE and POST.
REQ-007 cycle SHALL be 0 in the first CAPTURE cycle, increment every CAPTURE/POST cycle, saturate at all-ones, and hold in IDLE/DONE.
REQ-008 In CAPTURE/POST with cpu_valid=1, SHALL write {cpu_pc, cpu_instr, cycle} at the write pointer; the pointer wraps modulo DEPTH; count increments, saturating at DEPTH (oldest entry overwritten).
REQ-009 Trigger SHALL be evaluated only in CAPTURE with cpu_valid=1, per trig_mode; 00 never triggers regardless of trig_value.
REQ-010 The triggering instruction SHALL itself be written; trig_hit set; next state POST with post counter = POST_TRIG, or DONE directly if POST_TRIG=0.
REQ-011 In POST, each written entry SHALL decrement the post counter; the write bringing it to 0 SHALL move to DONE next edge.
REQ-012 If timeout!=0 and cycle==timeout in CAPTURE/POST, SHALL enter DONE next edge and set timeout_hit; a valid entry in that cycle is still written.
REQ-013 stop=1 in CAPTURE/POST SHALL enter DONE next edge; a valid entry in that cycle is still written; stop in IDLE/DONE has no effect.
REQ-014 Simultaneous trigger and stop/timeout SHALL go to DONE, setting every applicable flag.
REQ-015 Readout SHALL map rd_idx to physical address (wr_ptr - count + rd_idx) mod DEPTH, registered, one-cycle latency, available in every state.
REQ-016 rd_idx >= count SHALL yield rd_pc, rd_instr, rd_cycle = 0 (one-cycle latency).
REQ-017 Read and write to the same address in one cycle SHALL return the old contents.
REQ-018 busy and done SHALL be decoded directly from state, no added latency.

Reset
REQ-019 rst=1 SHALL immediately force IDLE, count=0, cycle=0, pointers 0, all flags 0, rd_* outputs 0; trace memory contents are not reset.
REQ-020 rst asserted mid-CAPTURE/POST SHALL abort the run; no entry is written in a cycle with rst=1.

Verification
REQ-021 arm; cpu_valid with pc 0..4; stop -> done=1, count=5; rd_idx=0 -> rd_pc=0 next cycle; rd_idx=4 -> rd_pc=4; rd_idx=5 -> all rd_* = 0.
REQ-022 Wrap, DEPTH=16: 20 consecutive valid pc 0..19, then stop -> count=16; rd_idx=0 -> rd_pc=4; rd_idx=15 -> rd_pc=19.
REQ-023 trig_mode=01, trig_value=10, POST_TRIG=4, pc 0,1,2,... every cycle -> trig_hit=1, DONE after pc 14 written, count=15, rd_idx=14 -> rd_pc=14; trig_mode=00 same stimulus -> no trigger.
REQ-024 timeout=50, cpu_valid=0 -> done=1 one cycle after cycle==50, timeout_hit=1, count=0, trig_hit=0.
REQ-025 Stop and trigger in same cycle -> DONE, trig_hit=1, triggering entry stored; arm=1 during CAPTURE -> count and cycle not cleared.
REQ-026 rst pulse after 3 entries -> busy=0, count=0, cycle=0 immediately; following arm starts a clean run.
